// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: scan FSM encoding and width helpers.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMMIT,
    ST_EMIT
  } scan_state_t;

  localparam int MAX_ROWS = 8;
  localparam int MAX_COLS = 8;

  // Width needed to index n items, never narrower than one bit.
  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_width(input int num_rows, input int num_cols);
    return min_width(num_rows * num_cols);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only if a pop
// happens in the same cycle.
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with frame debouncing and buffered key events.
// Define KEYPAD_RELEASE_EVENTS_EN to emit release events as well as presses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int NUM_ROWS        = 4,
  parameter  int NUM_COLS        = 4,
  parameter  int SETTLE_CYCLES   = 1000,
  parameter  int DEBOUNCE_FRAMES = 3,
  parameter  int FIFO_DEPTH      = 4,
  localparam int KEY_W           = key_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ROWS-1:0]          rows,
  output logic [NUM_COLS-1:0]          cols,
  output logic [NUM_ROWS*NUM_COLS-1:0] key_state,
  output logic                         any_key,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [KEY_W-1:0]             ev_code,
  output logic                         ev_press,
  output logic                         ev_overflow
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int COL_W    = min_width(NUM_COLS);
  localparam int SET_W    = min_width(SETTLE_CYCLES);
  localparam int CNT_W    = min_width(DEBOUNCE_FRAMES + 1);
`ifdef KEYPAD_RELEASE_EVENTS_EN
  localparam bit RELEASE_EN = 1'b1;
  localparam int EV_W       = KEY_W + 1;
`else
  localparam bit RELEASE_EN = 1'b0;
  localparam int EV_W       = KEY_W;
`endif

  if (SETTLE_CYCLES < 4) begin : g_bad_settle
    $fatal(1, "keypad_scanner: SETTLE_CYCLES must be >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "keypad_scanner: FIFO_DEPTH must be a power of two >= 2");
  end
  if (NUM_ROWS < 1 || NUM_ROWS > MAX_ROWS || NUM_COLS < 1 || NUM_COLS > MAX_COLS
      || DEBOUNCE_FRAMES < 1) begin : g_bad_geometry
    $fatal(1, "keypad_scanner: NUM_ROWS/NUM_COLS must be 1..8, DEBOUNCE_FRAMES >= 1");
  end

  scan_state_t         state_q, state_d;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [NUM_KEYS-1:0] old_q, old_d;
  logic [KEY_W-1:0]    emit_idx_q, emit_idx_d;
  logic [NUM_COLS-1:0] cols_q, cols_d;
  logic                overflow_q, overflow_d;
  logic [NUM_ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  logic                push, pop, fifo_full, fifo_empty;
  logic [EV_W-1:0]     push_data, head_data;

  assign pop = ev_valid && ev_ready;

  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    settle_cnt_d = settle_cnt_q;
    raw_d        = raw_q;
    prev_d       = prev_q;
    stable_cnt_d = stable_cnt_q;
    key_state_d  = key_state_q;
    old_d        = old_q;
    emit_idx_d   = emit_idx_q;
    cols_d       = cols_q;
    overflow_d   = overflow_q;
    sync1_d      = rows;
    sync2_d      = sync1_q;
    push         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        col_idx_d    = '0;
        settle_cnt_d = '0;
        cols_d       = ~NUM_COLS'(1);
        state_d      = ST_DRIVE;
      end
      ST_DRIVE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          for (int c = 0; c < NUM_COLS; c++) begin
            if (col_idx_q == COL_W'(c)) begin
              raw_d[r*NUM_COLS + c] = ~sync2_q[r];
            end
          end
        end
        if (col_idx_q == COL_W'(NUM_COLS - 1)) begin
          cols_d  = '1;
          state_d = ST_COMMIT;
        end else begin
          col_idx_d    = col_idx_q + 1'b1;
          settle_cnt_d = '0;
          cols_d       = ~(NUM_COLS'(1) << (col_idx_q + 1'b1));
          state_d      = ST_DRIVE;
        end
      end
      ST_COMMIT: begin
        cols_d = '1;
        if (raw_q == prev_q) begin
          if (stable_cnt_q != CNT_W'(DEBOUNCE_FRAMES)) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
          end
        end else begin
          stable_cnt_d = '0;
        end
        prev_d = raw_q;
        if (stable_cnt_d >= CNT_W'(DEBOUNCE_FRAMES) && raw_q != key_state_q) begin
          old_d       = key_state_q;
          key_state_d = raw_q;
          emit_idx_d  = '0;
          state_d     = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        // key_state_q already holds the new frame; old_q is what it replaced.
        push = (key_state_q[emit_idx_q] != old_q[emit_idx_q])
               && (RELEASE_EN || key_state_q[emit_idx_q]);
        if (emit_idx_q == KEY_W'(NUM_KEYS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          emit_idx_d = emit_idx_q + 1'b1;
        end
      end
      default: begin
        cols_d  = '1;
        state_d = ST_IDLE;
      end
    endcase

    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_idx_q    <= '0;
      settle_cnt_q <= '0;
      raw_q        <= '0;
      prev_q       <= '0;
      stable_cnt_q <= '0;
      key_state_q  <= '0;
      old_q        <= '0;
      emit_idx_q   <= '0;
      cols_q       <= '1;
      overflow_q   <= 1'b0;
      sync1_q      <= '1;
      sync2_q      <= '1;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      settle_cnt_q <= settle_cnt_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      stable_cnt_q <= stable_cnt_d;
      key_state_q  <= key_state_d;
      old_q        <= old_d;
      emit_idx_q   <= emit_idx_d;
      cols_q       <= cols_d;
      overflow_q   <= overflow_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
    end
  end

`ifdef KEYPAD_RELEASE_EVENTS_EN
  assign push_data = {emit_idx_q, key_state_q[emit_idx_q]};
  assign ev_code   = head_data[EV_W-1:1];
  assign ev_press  = head_data[0];
`else
  assign push_data = emit_idx_q;
  assign ev_code   = head_data;
  assign ev_press  = 1'b1;
`endif

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_data)
  );

  assign cols        = cols_q;
  assign key_state   = key_state_q;
  assign any_key     = |key_state_q;
  assign ev_valid    = !fifo_empty;
  assign ev_overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from cols and a
// scoreboard queue holds the events each stimulus step should produce.
module tb_keypad_scanner;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int NK    = NR * NC;
  localparam int DEPTH = 4;
`ifdef KEYPAD_RELEASE_EVENTS_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] rows;
  logic [NC-1:0] cols;
  logic [NK-1:0] key_state;
  logic          any_key;
  logic          ev_valid;
  logic          ev_ready;
  logic [3:0]    ev_code;
  logic          ev_press;
  logic          ev_overflow;

  logic [NK-1:0] pressed;
  logic [NK-1:0] exp_state;
  bit            exp_overflow;
  logic [4:0]    exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows = '1;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (pressed[r*NC + c] && !cols[c]) begin
          rows[r] = 1'b0;
        end
      end
    end
  end

  keypad_scanner #(
    .NUM_ROWS        (NR),
    .NUM_COLS        (NC),
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_FRAMES (2),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rows        (rows),
    .cols        (cols),
    .key_state   (key_state),
    .any_key     (any_key),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_press    (ev_press),
    .ev_overflow (ev_overflow)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every popped event must match the oldest expected event.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL unexpected_event: observed code=%0d press=%0b expected no event",
               ev_code, ev_press);
      end else begin
        e = exp_q.pop_front();
        check_output("ev_code", 32'(ev_code), 32'(e[4:1]));
        check_output("ev_press", 32'(ev_press), 32'(e[0]));
      end
    end
  end

  // Returns at the negedge of the next COMMIT cycle (cols leave the last column).
  task automatic wait_commit();
    logic [NC-1:0] prev;
    bit            seen;
    prev = cols;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (prev == 4'h7 && cols == 4'hF) seen = 1'b1;
      prev = cols;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL commit_timeout: observed no commit in 200 cycles, expected one");
    end
  endtask

  // Change the held keys right at a frame boundary and check the exact commit point.
  task automatic apply_stimulus(input logic [NK-1:0] new_map);
    logic [NK-1:0] old_map;
    int            first;
    int            npush;
    bit            was_empty;
    old_map   = exp_state;
    first     = -1;
    npush     = 0;
    was_empty = (exp_q.size() == 0);
    wait_commit();
    pressed = new_map;
    for (int i = 0; i < NK; i++) begin
      if (old_map[i] != new_map[i] && (REL_EN || new_map[i])) begin
        if (first < 0) first = i;
        npush++;
        if (ev_ready || exp_q.size() < DEPTH) exp_q.push_back({4'(i), new_map[i]});
        else exp_overflow = 1'b1;
      end
    end
    repeat (3) wait_commit();
    check_output("key_state_before_commit", 32'(key_state), 32'(old_map));
    @(negedge clk);
    check_output("key_state_after_commit", 32'(key_state), 32'(new_map));
    check_output("any_key", 32'(any_key), 32'(|new_map));
    exp_state = new_map;
    if (ev_ready && npush > 0 && was_empty) begin
      repeat (first) @(negedge clk);
      check_output("ev_valid_at_push", 32'(ev_valid), 32'd0);
      @(negedge clk);
      check_output("ev_valid_after_push", 32'(ev_valid), 32'd1);
    end
    repeat (NK + 8) @(negedge clk);
    if (ev_ready) check_output("events_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cols"}, 32'(cols), 32'hF);
    check_output({tag, "_key_state"}, 32'(key_state), 32'h0);
    check_output({tag, "_any_key"}, 32'(any_key), 32'h0);
    check_output({tag, "_ev_valid"}, 32'(ev_valid), 32'h0);
    check_output({tag, "_ev_code"}, 32'(ev_code), 32'h0);
    check_output({tag, "_ev_overflow"}, 32'(ev_overflow), 32'h0);
    if (REL_EN) check_output({tag, "_ev_press"}, 32'(ev_press), 32'h0);
  endtask

  initial begin
    int         keys[6];
    bit         found;
    rst_n        = 1'b0;
    ev_ready     = 1'b1;
    pressed      = '0;
    exp_state    = '0;
    exp_overflow = 1'b0;
    keys         = '{3, 6, 8, 10, 12, 15};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    $display("[TB] press key 5 and hold");
    apply_stimulus(16'h0020);
    repeat (3) wait_commit();
    check_output("held_no_event", 32'(ev_valid), 32'd0);
    check_output("held_key_state", 32'(key_state), 32'h0020);

    $display("[TB] release key 5");
    apply_stimulus(16'h0000);

    $display("[TB] one-frame bounce on key 5");
    wait_commit();
    pressed = 16'h0020;
    wait_commit();
    pressed = 16'h0000;
    repeat (3) wait_commit();
    check_output("bounce_key_state", 32'(key_state), 32'h0);
    check_output("bounce_no_event", 32'(ev_valid), 32'd0);

    $display("[TB] keys 2 and 9 in the same frame");
    apply_stimulus(16'h0204);
    apply_stimulus(16'h0000);

    $display("[TB] overflow with consumer stalled");
    ev_ready = 1'b0;
    foreach (keys[k]) begin
      apply_stimulus(NK'(1) << keys[k]);
      apply_stimulus(16'h0000);
    end
    check_output("overflow_set", 32'(ev_overflow), 32'(exp_overflow));
    check_output("overflow_valid_held", 32'(ev_valid), 32'd1);
    ev_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_output("overflow_drained", exp_q.size(), 32'd0);
    check_output("overflow_sticky", 32'(ev_overflow), 32'd1);
    check_output("overflow_empty", 32'(ev_valid), 32'd0);

    $display("[TB] reset during column 2 drive with key 0 held");
    apply_stimulus(16'h0001);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (cols == 4'hB) found = 1'b1;
    end
    check_output("reach_col2_drive", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    exp_state    = '0;
    exp_overflow = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({4'd0, 1'b1});
    repeat (3) wait_commit();
    check_output("redetect_before_commit", 32'(key_state), 32'h0);
    @(negedge clk);
    check_output("redetect_key_state", 32'(key_state), 32'h0001);
    check_output("redetect_any_key", 32'(any_key), 32'd1);
    repeat (NK + 8) @(negedge clk);
    check_output("redetect_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
